vend_sched: RTL and testbench

Round-robin dispense scheduler for the cola vending datapath. It accumulates coins independently on CH_NUM customer coin slots and arbitrates the single shared cola dispenser among slots that have reached the price. It issues one timed dispense per grant and refunds coins that arrive while a slot is already fully paid. It sits between the coin-slot inputs (one synchronous pulse per coin) and the dispenser actuator.

---
 rtl/vend_sched.sv | 140 ++++++++++++++
 tb/tb_vend_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sched.sv
// Round-robin cola dispense scheduler: per-slot coin credit, fair arbitration of
// the shared dispenser, a fixed-length dispense per grant, and refunds of over-payment.
module vend_sched #(
  parameter int CH_NUM   = 4,
  parameter int CH_W     = 2,
  parameter int PRICE    = 3,
  parameter int DISP_CYC = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [CH_NUM-1:0]   pi_money,
  output logic                po_cola,
  output logic [CH_W-1:0]     po_chan,
  output logic                po_busy,
  output logic [CH_NUM-1:0]   po_refund,
  output logic [CH_NUM-1:0]   po_ready,
  output logic                o_dbg_state,
  output logic [CH_NUM*3-1:0] o_dbg_credit
);

  localparam int CRED_W = 3;
  localparam int CNT_W  = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DISP = 1'b1
  } state_t;

  // Handshake: pi_money is a one-cycle strobe per coin with no backpressure; a
  // coin that cannot be credited is returned on po_refund one cycle later.
  // po_ready is level status (slot fully paid), consumed by the internal arbiter.

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CRED_W-1:0]       r_credit [CH_NUM];
  logic [CH_W-1:0]         r_last;
  logic [CH_W-1:0]         r_chan;
  logic [CH_W-1:0]         w_winner;
  logic                    w_found;
  logic                    w_grant;
  logic                    r_cola;
  logic [CH_NUM-1:0]       r_refund;
  logic [CH_NUM-1:0]       w_ready;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_ready[i] = (r_credit[i] == CRED_W'(PRICE));
    end
  end

  // Search begins one past the last winner so every waiting slot is reached.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      if (!w_found && w_ready[CH_W'((int'(r_last) + i) % CH_NUM)]) begin
        w_found  = 1'b1;
        w_winner = CH_W'((int'(r_last) + i) % CH_NUM);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_DISP;
        end
      end
      S_DISP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cola  <= 1'b0;
      r_chan  <= '0;
      r_last  <= CH_W'(CH_NUM - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cola  <= w_grant;
      if (w_grant) begin
        r_cnt  <= CNT_W'(DISP_CYC - 1);
        r_chan <= w_winner;
        r_last <= w_winner;
      end else if (r_state == S_DISP && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // A coin landing on the grant edge starts the next cola rather than being refunded.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_credit[i] <= '0;
      end
      r_refund <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_refund[i] <= 1'b0;
        if (w_grant && w_winner == CH_W'(i)) begin
          r_credit[i] <= pi_money[i] ? CRED_W'(1) : '0;
        end else if (pi_money[i]) begin
          if (r_credit[i] < CRED_W'(PRICE)) begin
            r_credit[i] <= r_credit[i] + 1'b1;
          end else begin
            r_refund[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    o_dbg_credit = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      o_dbg_credit[i*CRED_W +: CRED_W] = r_credit[i];
    end
  end

  assign po_cola     = r_cola;
  assign po_chan     = r_chan;
  assign po_busy     = (r_state == S_DISP);
  assign po_refund   = r_refund;
  assign po_ready    = w_ready;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vend_sched.sv
// Bench for vend_sched: directed scenarios with an expected-channel queue, then a
// random coin phase checked for coin conservation, pulse spacing and fairness.
module tb_vend_sched;

  localparam int CH_NUM   = 4;
  localparam int CH_W     = 2;
  localparam int PRICE    = 3;
  localparam int DISP_CYC = 4;

  logic                sys_clk   = 1'b0;
  logic                sys_rst_n = 1'b0;
  logic [CH_NUM-1:0]   pi_money  = '0;
  logic                po_cola;
  logic [CH_W-1:0]     po_chan;
  logic                po_busy;
  logic [CH_NUM-1:0]   po_refund;
  logic [CH_NUM-1:0]   po_ready;
  logic                o_dbg_state;
  logic [CH_NUM*3-1:0] o_dbg_credit;

  vend_sched #(
    .CH_NUM  (CH_NUM),
    .CH_W    (CH_W),
    .PRICE   (PRICE),
    .DISP_CYC(DISP_CYC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pi_money    (pi_money),
    .po_cola     (po_cola),
    .po_chan     (po_chan),
    .po_busy     (po_busy),
    .po_refund   (po_refund),
    .po_ready    (po_ready),
    .o_dbg_state (o_dbg_state),
    .o_dbg_credit(o_dbg_credit)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [CH_W-1:0]   exp_q[$];
  int                cola_t[$];
  int                cmp_cnt    = 0;
  int                fail_cnt   = 0;
  int                cyc        = 0;
  int                cola_cnt   = 0;
  int                refund_cnt = 0;
  int                coin_cnt   = 0;
  int                last_cola  = 0;
  int                min_gap    = 1000000;
  int                max_skip   = 0;
  int                skip [CH_NUM];
  bit                have_last  = 1'b0;
  bit                sb_en      = 1'b1;
  logic [CH_NUM-1:0] prev_ready = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cred(input int i);
    return int'(o_dbg_credit[i*3 +: 3]);
  endfunction

  task automatic monitor();
    int gap;
    if (po_cola) begin
      cola_cnt++;
      if (have_last) begin
        gap = cyc - last_cola;
        if (gap < min_gap) min_gap = gap;
      end
      have_last = 1'b1;
      last_cola = cyc;
      cola_t.push_back(cyc);
      for (int j = 0; j < CH_NUM; j++) begin
        if (j == int'(po_chan)) skip[j] = 0;
        else if (prev_ready[j]) begin
          skip[j]++;
          if (skip[j] > max_skip) max_skip = skip[j];
        end else skip[j] = 0;
      end
      if (sb_en) begin
        check("sb_cola_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_chan", 32'(po_chan), 32'(exp_q.pop_front()));
        check("busy_with_cola", 32'(po_busy), 32'd1);
      end
    end
    refund_cnt += $countones(po_refund);
    prev_ready = po_ready;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [CH_NUM-1:0] m);
    pi_money = m;
    coin_cnt += $countones(m);
  endtask

  task automatic do_reset();
    pi_money  = '0;
    sys_rst_n = 1'b0;
    ticks(2);
    sys_rst_n = 1'b1;
    for (int j = 0; j < CH_NUM; j++) skip[j] = 0;
  endtask

  initial begin
    int k_cyc;
    int n0;
    int r0;
    int busy_cnt;
    int residual;
    logic [CH_NUM-1:0] m;

    for (int j = 0; j < CH_NUM; j++) skip[j] = 0;

    // reset state
    ticks(2);
    check("rst_cola", 32'(po_cola), 32'd0);
    check("rst_chan", 32'(po_chan), 32'd0);
    check("rst_busy", 32'(po_busy), 32'd0);
    check("rst_refund", 32'(po_refund), 32'd0);
    check("rst_ready", 32'(po_ready), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    sys_rst_n = 1'b1;
    ticks(1);

    // slot 2 pays one coin per cycle, then one timed dispense
    drive(4'b0100);
    ticks(3);
    check("t1_ready", 32'(po_ready), 32'b0100);
    check("t1_no_cola_yet", 32'(po_cola), 32'd0);
    k_cyc = cyc;
    exp_q.push_back(2'd2);
    drive(4'b0000);
    n0 = cola_cnt;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (po_busy) busy_cnt++;
    end
    check("t1_cola_latency", 32'(last_cola), 32'(k_cyc + 1));
    check("t1_busy_len", 32'(busy_cnt), 32'(DISP_CYC));
    check("t1_cola_count", 32'(cola_cnt - n0), 32'd1);
    check("t1_credit2", 32'(cred(2)), 32'd0);
    check("t1_chan_hold", 32'(po_chan), 32'd2);
    check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // all four slots paid together after reset: served 0,1,2,3 five cycles apart
    do_reset();
    cola_t.delete();
    r0 = refund_cnt;
    for (int i = 0; i < CH_NUM; i++) exp_q.push_back(CH_W'(i));
    drive(4'b1111);
    ticks(3);
    check("t2_ready", 32'(po_ready), 32'b1111);
    drive(4'b0000);
    ticks(25);
    check("t2_cola_count", 32'(cola_t.size()), 32'd4);
    for (int i = 1; i < cola_t.size(); i++)
      check("t2_cola_gap", 32'(cola_t[i] - cola_t[i-1]), 32'(DISP_CYC + 1));
    check("t2_no_refund", 32'(refund_cnt - r0), 32'd0);
    check("t2_sb_drained", 32'(exp_q.size()), 32'd0);

    // slot 1 waits behind slot 0 and gets two extra coins refunded
    do_reset();
    r0 = refund_cnt;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    drive(4'b0011);
    ticks(3);
    drive(4'b0000);
    tick();
    drive(4'b0010);
    tick();
    check("t3_refund_a", 32'(po_refund), 32'b0010);
    drive(4'b0000);
    tick();
    check("t3_refund_gap", 32'(po_refund), 32'b0000);
    drive(4'b0010);
    tick();
    check("t3_refund_b", 32'(po_refund), 32'b0010);
    check("t3_credit1", 32'(cred(1)), 32'(PRICE));
    check("t3_ready", 32'(po_ready), 32'b0010);
    drive(4'b0000);
    ticks(10);
    check("t3_refund_total", 32'(refund_cnt - r0), 32'd2);
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

    // coin coincident with its own grant carries over
    exp_q.push_back(2'd0);
    drive(4'b0001);
    ticks(4);
    drive(4'b0000);
    check("t4_cola", 32'(po_cola), 32'd1);
    check("t4_no_refund", 32'(po_refund), 32'd0);
    check("t4_credit0", 32'(cred(0)), 32'd1);
    ticks(8);
    check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // reset during the second dispense cycle
    exp_q.push_back(2'd1);
    drive(4'b1010);
    ticks(3);
    drive(4'b0000);
    tick();
    tick();
    check("t5_busy_pre", 32'(po_busy), 32'd1);
    check("t5_ready_pre", 32'(po_ready), 32'b1000);
    sys_rst_n = 1'b0;
    #1;
    check("t5_busy_async", 32'(po_busy), 32'd0);
    check("t5_cola_async", 32'(po_cola), 32'd0);
    check("t5_ready_async", 32'(po_ready), 32'd0);
    check("t5_state_async", 32'(o_dbg_state), 32'd0);
    ticks(2);
    sys_rst_n = 1'b1;
    n0 = cola_cnt;
    ticks(20);
    check("t5_no_cola", 32'(cola_cnt - n0), 32'd0);
    check("t5_credit_sum", 32'(cred(0) + cred(1) + cred(2) + cred(3)), 32'd0);
    check("t5_sb_drained", 32'(exp_q.size()), 32'd0);

    // random coins with invariant checks
    sb_en      = 1'b0;
    coin_cnt   = 0;
    cola_cnt   = 0;
    refund_cnt = 0;
    have_last  = 1'b0;
    min_gap    = 1000000;
    max_skip   = 0;
    for (int j = 0; j < CH_NUM; j++) skip[j] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < CH_NUM; b++) m[b] = ($urandom_range(0, 9) < 3);
      drive(m);
      tick();
    end
    drive(4'b0000);
    ticks(40);
    residual = 0;
    for (int i = 0; i < CH_NUM; i++) residual += cred(i);
    check("rnd_conservation", 32'(PRICE * cola_cnt + refund_cnt + residual), 32'(coin_cnt));
    check("rnd_min_gap_ok", 32'(min_gap >= DISP_CYC + 1), 32'd1);
    check("rnd_fairness_ok", 32'(max_skip <= CH_NUM - 1), 32'd1);
    check("rnd_activity", 32'(cola_cnt >= 100), 32'd1);
    check("rnd_idle_end", 32'(po_busy), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
